// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: control-word layout, ALUOp encodings and the bubble control word.
// Used by the ID/EX, EX/MEM and MEM/WB stages.
package pipe_pkg;

   localparam int CTRL_IN_W = 9;
   localparam int CTRL_W    = 8;

   // Bit positions inside the registered control word (ctrl_o)
   localparam int CTRL_REGWRITE = 7;
   localparam int CTRL_MEMTOREG = 6;
   localparam int CTRL_MEMREAD  = 5;
   localparam int CTRL_MEMWRITE = 4;
   localparam int CTRL_ALUSRC   = 3;
   localparam int CTRL_ALUOP_HI = 2;
   localparam int CTRL_ALUOP_LO = 1;
   localparam int CTRL_REGDST   = 0;

   // The decoded word from ID carries UsesRt below the registered fields
   localparam int CTRL_IN_USESRT = 0;

   typedef enum logic [1:0] {
      ALUOP_ADD   = 2'b00,
      ALUOP_SUB   = 2'b01,
      ALUOP_FUNCT = 2'b10,
      ALUOP_IMM   = 2'b11
   } aluop_e;

   localparam logic [CTRL_W-1:0] BUBBLE_CTRL = '0;

   function automatic logic [CTRL_W-1:0] stripUsesRt(input logic [CTRL_IN_W-1:0] ctrl);
      return ctrl[CTRL_IN_W-1:1];
   endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detection: a load in ID/EX whose destination feeds the instruction in IF/ID.
module hazard_detect
   import pipe_pkg::*;
#(
   parameter int REG_W = 5
) (
   input  logic             i_exMemRead,
   input  logic             i_exValid,
   input  logic [REG_W-1:0] i_exRt,
   input  logic [REG_W-1:0] i_idRs,
   input  logic [REG_W-1:0] i_idRt,
   input  logic             i_idUsesRt,
   output logic             o_hazard
);

   logic w_rtNonZero;
   logic w_rsMatch;
   logic w_rtMatch;

   // $zero is never a real dependency, so a load into r0 cannot stall
   assign w_rtNonZero = (i_exRt != '0);
   assign w_rsMatch   = (i_exRt == i_idRs);
   assign w_rtMatch   = i_idUsesRt & (i_exRt == i_idRt);

   assign o_hazard = i_exMemRead & i_exValid & w_rtNonZero & (w_rsMatch | w_rtMatch);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall and bubble insertion.
// Bubbles carry zero indices so EX forwarding can never match them.
module id_ex_stage
   import pipe_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int REG_W  = 5
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 stall_i,
   input  logic                 flush_i,
   input  logic [CTRL_IN_W-1:0] ctrl_i,
   input  logic [DATA_W-1:0]    rs_data_i,
   input  logic [DATA_W-1:0]    rt_data_i,
   input  logic [DATA_W-1:0]    imm_i,
   input  logic [REG_W-1:0]     rs_i,
   input  logic [REG_W-1:0]     rt_i,
   input  logic [REG_W-1:0]     rd_i,
   output logic [CTRL_W-1:0]    ctrl_o,
   output logic [DATA_W-1:0]    rs_data_o,
   output logic [DATA_W-1:0]    rt_data_o,
   output logic [DATA_W-1:0]    imm_o,
   output logic [REG_W-1:0]     rs_o,
   output logic [REG_W-1:0]     rt_o,
   output logic [REG_W-1:0]     rd_o,
   output logic                 valid_o,
   output logic                 pc_write_o,
   output logic                 ifid_write_o,
   output logic [31:0]          bubble_cnt_o
);

   logic [CTRL_W-1:0] r_ctrl;
   logic [DATA_W-1:0] r_rsData;
   logic [DATA_W-1:0] r_rtData;
   logic [DATA_W-1:0] r_imm;
   logic [REG_W-1:0]  r_rs;
   logic [REG_W-1:0]  r_rt;
   logic [REG_W-1:0]  r_rd;
   logic              r_valid;
   logic [31:0]       r_bubbleCnt;
   logic              w_hazard;

   hazard_detect #(
      .REG_W (REG_W)
   ) u_hazard (
      .i_exMemRead (r_ctrl[CTRL_MEMREAD]),
      .i_exValid   (r_valid),
      .i_exRt      (r_rt),
      .i_idRs      (rs_i),
      .i_idRt      (rt_i),
      .i_idUsesRt  (ctrl_i[CTRL_IN_USESRT]),
      .o_hazard    (w_hazard)
   );

   // A flush squashes the dependent instruction itself, so it does not count as a load-use bubble
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_ctrl      <= BUBBLE_CTRL;
         r_rsData    <= '0;
         r_rtData    <= '0;
         r_imm       <= '0;
         r_rs        <= '0;
         r_rt        <= '0;
         r_rd        <= '0;
         r_valid     <= 1'b0;
         r_bubbleCnt <= '0;
      end else if (!stall_i) begin
         if (flush_i || w_hazard) begin
            r_ctrl   <= BUBBLE_CTRL;
            r_rsData <= '0;
            r_rtData <= '0;
            r_imm    <= '0;
            r_rs     <= '0;
            r_rt     <= '0;
            r_rd     <= '0;
            r_valid  <= 1'b0;
            if (!flush_i) begin
               r_bubbleCnt <= r_bubbleCnt + 32'd1;
            end
         end else begin
            r_ctrl   <= stripUsesRt(ctrl_i);
            r_rsData <= rs_data_i;
            r_rtData <= rt_data_i;
            r_imm    <= imm_i;
            r_rs     <= rs_i;
            r_rt     <= rt_i;
            r_rd     <= rd_i;
            r_valid  <= 1'b1;
         end
      end
   end

   assign pc_write_o   = ~w_hazard & ~stall_i;
   assign ifid_write_o = ~w_hazard & ~stall_i;

   assign ctrl_o       = r_ctrl;
   assign rs_data_o    = r_rsData;
   assign rt_data_o    = r_rtData;
   assign imm_o        = r_imm;
   assign rs_o         = r_rs;
   assign rt_o         = r_rt;
   assign rd_o         = r_rd;
   assign valid_o      = r_valid;
   assign bubble_cnt_o = r_bubbleCnt;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: expected ID/EX contents are queued as stimulus is driven
// and compared one cycle later; hazard outputs are checked combinationally.
module tb_id_ex_stage;

   localparam logic [8:0] LW9   = 9'b111010000;
   localparam logic [7:0] LW8   = 8'b11101000;
   localparam logic [8:0] RT9   = 9'b100001011;
   localparam logic [7:0] RT8   = 8'b10000101;
   localparam logic [8:0] ADDI9 = 9'b100010000;
   localparam logic [7:0] ADDI8 = 8'b10001000;

   typedef struct packed {
      logic [7:0]  ctrl;
      logic [31:0] rsData;
      logic [31:0] rtData;
      logic [31:0] imm;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [4:0]  rd;
      logic        valid;
      logic [31:0] cnt;
   } snap_t;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        stall_i;
   logic        flush_i;
   logic [8:0]  ctrl_i;
   logic [31:0] rs_data_i;
   logic [31:0] rt_data_i;
   logic [31:0] imm_i;
   logic [4:0]  rs_i;
   logic [4:0]  rt_i;
   logic [4:0]  rd_i;
   logic [7:0]  ctrl_o;
   logic [31:0] rs_data_o;
   logic [31:0] rt_data_o;
   logic [31:0] imm_o;
   logic [4:0]  rs_o;
   logic [4:0]  rt_o;
   logic [4:0]  rd_o;
   logic        valid_o;
   logic        pc_write_o;
   logic        ifid_write_o;
   logic [31:0] bubble_cnt_o;

   snap_t obs;
   snap_t expSnap;
   snap_t sbq[$];
   int    total = 0;
   int    bad = 0;
   int    expCnt = 0;

   assign obs = {ctrl_o, rs_data_o, rt_data_o, imm_o, rs_o, rt_o, rd_o, valid_o, bubble_cnt_o};

   id_ex_stage #(
      .DATA_W (32),
      .REG_W  (5)
   ) dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .stall_i      (stall_i),
      .flush_i      (flush_i),
      .ctrl_i       (ctrl_i),
      .rs_data_i    (rs_data_i),
      .rt_data_i    (rt_data_i),
      .imm_i        (imm_i),
      .rs_i         (rs_i),
      .rt_i         (rt_i),
      .rd_i         (rd_i),
      .ctrl_o       (ctrl_o),
      .rs_data_o    (rs_data_o),
      .rt_data_o    (rt_data_o),
      .imm_o        (imm_o),
      .rs_o         (rs_o),
      .rt_o         (rt_o),
      .rd_o         (rd_o),
      .valid_o      (valid_o),
      .pc_write_o   (pc_write_o),
      .ifid_write_o (ifid_write_o),
      .bubble_cnt_o (bubble_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   function automatic snap_t mkSnap(input logic [7:0] c, input logic [31:0] a, input logic [31:0] b,
                                    input logic [31:0] im, input logic [4:0] rs, input logic [4:0] rt,
                                    input logic [4:0] rd, input logic v, input logic [31:0] cnt);
      snap_t s;
      s.ctrl = c; s.rsData = a; s.rtData = b; s.imm = im;
      s.rs = rs; s.rt = rt; s.rd = rd; s.valid = v; s.cnt = cnt;
      return s;
   endfunction

   function automatic snap_t bubbleSnap(input logic [31:0] cnt);
      return mkSnap(8'h00, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 1'b0, cnt);
   endfunction

   task automatic applyStimulus(input logic [8:0] c, input logic [4:0] rs, input logic [4:0] rt,
                                input logic [4:0] rd, input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] im);
      ctrl_i = c; rs_i = rs; rt_i = rt; rd_i = rd;
      rs_data_i = a; rt_data_i = b; imm_i = im;
   endtask

   task automatic advance();
      @(posedge clk_i);
      #1;
   endtask

   task automatic test_reset();
      rst_i = 1'b0; stall_i = 1'b0; flush_i = 1'b0;
      applyStimulus(9'h0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0);
      #3;
      total++;
      if (obs !== snap_t'(0)) begin bad++; $display("FAIL reset_state: got=%h want=0", obs); end
      total++;
      if ({pc_write_o, ifid_write_o} !== 2'b11) begin
         bad++; $display("FAIL reset_pcwrite: got=%b want=11", {pc_write_o, ifid_write_o});
      end
      @(negedge clk_i);
      rst_i = 1'b1;
   endtask

   task automatic test_capture();
      applyStimulus(9'h100, 5'd3, 5'd4, 5'd5, 32'h11, 32'h22, 32'h33);
      sbq.push_back(mkSnap(8'h80, 32'h11, 32'h22, 32'h33, 5'd3, 5'd4, 5'd5, 1'b1, expCnt));
      #1;
      total++;
      if (pc_write_o !== 1'b1) begin bad++; $display("FAIL capture_pcwrite: got=%b want=1", pc_write_o); end
      advance();
      total++; expSnap = sbq.pop_front();
      if (obs !== expSnap) begin bad++; $display("FAIL capture: got=%h want=%h", obs, expSnap); end
      total++;
      if (pc_write_o !== 1'b1) begin bad++; $display("FAIL capture_pcwrite_after: got=%b want=1", pc_write_o); end
   endtask

   task automatic test_load_use();
      applyStimulus(LW9, 5'd2, 5'd8, 5'd0, 32'hA, 32'hB, 32'hC);
      sbq.push_back(mkSnap(LW8, 32'hA, 32'hB, 32'hC, 5'd2, 5'd8, 5'd0, 1'b1, expCnt));
      advance();
      total++; expSnap = sbq.pop_front();
      if (obs !== expSnap) begin bad++; $display("FAIL lw_capture: got=%h want=%h", obs, expSnap); end
      applyStimulus(RT9, 5'd8, 5'd7, 5'd9, 32'h80, 32'h81, 32'h82);
      #1;
      total++;
      if ({pc_write_o, ifid_write_o} !== 2'b00) begin
         bad++; $display("FAIL load_use_hold: got=%b want=00", {pc_write_o, ifid_write_o});
      end
      expCnt++;
      sbq.push_back(bubbleSnap(expCnt));
      advance();
      total++; expSnap = sbq.pop_front();
      if (obs !== expSnap) begin bad++; $display("FAIL load_use_bubble: got=%h want=%h", obs, expSnap); end
      total++;
      if ({pc_write_o, ifid_write_o} !== 2'b11) begin
         bad++; $display("FAIL hazard_clear: got=%b want=11", {pc_write_o, ifid_write_o});
      end
      sbq.push_back(mkSnap(RT8, 32'h80, 32'h81, 32'h82, 5'd8, 5'd7, 5'd9, 1'b1, expCnt));
      advance();
      total++; expSnap = sbq.pop_front();
      if (obs !== expSnap) begin bad++; $display("FAIL held_instr: got=%h want=%h", obs, expSnap); end
   endtask

   task automatic test_no_false_hazard();
      applyStimulus(LW9, 5'd1, 5'd0, 5'd0, 32'h1, 32'h2, 32'h3);
      sbq.push_back(mkSnap(LW8, 32'h1, 32'h2, 32'h3, 5'd1, 5'd0, 5'd0, 1'b1, expCnt));
      advance();
      total++; expSnap = sbq.pop_front();
      if (obs !== expSnap) begin bad++; $display("FAIL lw_r0_capture: got=%h want=%h", obs, expSnap); end
      applyStimulus(RT9, 5'd0, 5'd0, 5'd3, 32'h4, 32'h5, 32'h6);
      #1;
      total++;
      if (pc_write_o !== 1'b1) begin bad++; $display("FAIL r0_no_stall: got=%b want=1", pc_write_o); end
      sbq.push_back(mkSnap(RT8, 32'h4, 32'h5, 32'h6, 5'd0, 5'd0, 5'd3, 1'b1, expCnt));
      advance();
      total++; expSnap = sbq.pop_front();
      if (obs !== expSnap) begin bad++; $display("FAIL r0_follow: got=%h want=%h", obs, expSnap); end
      applyStimulus(LW9, 5'd1, 5'd9, 5'd0, 32'h7, 32'h8, 32'h9);
      sbq.push_back(mkSnap(LW8, 32'h7, 32'h8, 32'h9, 5'd1, 5'd9, 5'd0, 1'b1, expCnt));
      advance();
      total++; expSnap = sbq.pop_front();
      if (obs !== expSnap) begin bad++; $display("FAIL lw_r9_capture: got=%h want=%h", obs, expSnap); end
      applyStimulus(ADDI9, 5'd4, 5'd9, 5'd0, 32'h10, 32'h20, 32'h30);
      #1;
      total++;
      if (pc_write_o !== 1'b1) begin bad++; $display("FAIL usesrt0_no_stall: got=%b want=1", pc_write_o); end
      sbq.push_back(mkSnap(ADDI8, 32'h10, 32'h20, 32'h30, 5'd4, 5'd9, 5'd0, 1'b1, expCnt));
      advance();
      total++; expSnap = sbq.pop_front();
      if (obs !== expSnap) begin bad++; $display("FAIL addi_follow: got=%h want=%h", obs, expSnap); end
   endtask

   task automatic test_flush_hazard();
      applyStimulus(LW9, 5'd1, 5'd6, 5'd0, 32'h61, 32'h62, 32'h63);
      sbq.push_back(mkSnap(LW8, 32'h61, 32'h62, 32'h63, 5'd1, 5'd6, 5'd0, 1'b1, expCnt));
      advance();
      total++; expSnap = sbq.pop_front();
      if (obs !== expSnap) begin bad++; $display("FAIL lw_r6_capture: got=%h want=%h", obs, expSnap); end
      applyStimulus(RT9, 5'd1, 5'd6, 5'd2, 32'h64, 32'h65, 32'h66);
      flush_i = 1'b1;
      #1;
      total++;
      if (pc_write_o !== 1'b0) begin bad++; $display("FAIL flush_hazard_hold: got=%b want=0", pc_write_o); end
      sbq.push_back(bubbleSnap(expCnt));
      advance();
      flush_i = 1'b0;
      total++; expSnap = sbq.pop_front();
      if (obs !== expSnap) begin bad++; $display("FAIL flush_bubble: got=%h want=%h", obs, expSnap); end
   endtask

   task automatic test_stall();
      snap_t lwSnap;
      lwSnap = mkSnap(LW8, 32'hC1, 32'hC2, 32'hC3, 5'd3, 5'd12, 5'd0, 1'b1, expCnt);
      applyStimulus(LW9, 5'd3, 5'd12, 5'd0, 32'hC1, 32'hC2, 32'hC3);
      sbq.push_back(lwSnap);
      advance();
      total++; expSnap = sbq.pop_front();
      if (obs !== expSnap) begin bad++; $display("FAIL lw_r12_capture: got=%h want=%h", obs, expSnap); end
      applyStimulus(RT9, 5'd1, 5'd12, 5'd4, 32'hD1, 32'hD2, 32'hD3);
      stall_i = 1'b1;
      for (int k = 0; k < 3; k++) begin
         #1;
         total++;
         if ({pc_write_o, ifid_write_o} !== 2'b00) begin
            bad++; $display("FAIL stall_pcwrite: got=%b want=00", {pc_write_o, ifid_write_o});
         end
         sbq.push_back(lwSnap);
         advance();
         total++; expSnap = sbq.pop_front();
         if (obs !== expSnap) begin bad++; $display("FAIL stall_freeze: got=%h want=%h", obs, expSnap); end
      end
      stall_i = 1'b0;
      #1;
      total++;
      if (pc_write_o !== 1'b0) begin bad++; $display("FAIL hazard_after_stall: got=%b want=0", pc_write_o); end
      expCnt++;
      sbq.push_back(bubbleSnap(expCnt));
      advance();
      total++; expSnap = sbq.pop_front();
      if (obs !== expSnap) begin bad++; $display("FAIL stall_bubble: got=%h want=%h", obs, expSnap); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] a, b, im;
      logic [4:0]  dst;
      for (int i = 0; i < 5; i++) begin
         dst = 5'(16 + i);
         a = $urandom; b = $urandom; im = $urandom;
         applyStimulus(LW9, 5'd1, dst, 5'd0, a, b, im);
         sbq.push_back(mkSnap(LW8, a, b, im, 5'd1, dst, 5'd0, 1'b1, expCnt));
         advance();
         total++; expSnap = sbq.pop_front();
         if (obs !== expSnap) begin bad++; $display("FAIL b2b_lw: got=%h want=%h", obs, expSnap); end
         a = $urandom; b = $urandom; im = $urandom;
         applyStimulus(RT9, dst, 5'd2, 5'd3, a, b, im);
         #1;
         total++;
         if (pc_write_o !== 1'b0) begin bad++; $display("FAIL b2b_hold: got=%b want=0", pc_write_o); end
         expCnt++;
         sbq.push_back(bubbleSnap(expCnt));
         sbq.push_back(mkSnap(RT8, a, b, im, dst, 5'd2, 5'd3, 1'b1, expCnt));
         advance();
         total++; expSnap = sbq.pop_front();
         if (obs !== expSnap) begin bad++; $display("FAIL b2b_bubble: got=%h want=%h", obs, expSnap); end
         advance();
         total++; expSnap = sbq.pop_front();
         if (obs !== expSnap) begin bad++; $display("FAIL b2b_dependent: got=%h want=%h", obs, expSnap); end
      end
   endtask

   task automatic test_async_reset();
      total++;
      if ({valid_o, bubble_cnt_o} !== {1'b1, 32'd7}) begin
         bad++; $display("FAIL pre_reset_state: got=%h want=%h", {valid_o, bubble_cnt_o}, {1'b1, 32'd7});
      end
      #2;
      rst_i = 1'b0;
      #1;
      total++;
      if (obs !== snap_t'(0)) begin bad++; $display("FAIL async_reset_clear: got=%h want=0", obs); end
      stall_i = 1'b1;
      #1;
      total++;
      if ({pc_write_o, ifid_write_o} !== 2'b00) begin
         bad++; $display("FAIL stall_gates_pcwrite: got=%b want=00", {pc_write_o, ifid_write_o});
      end
      @(negedge clk_i);
      rst_i = 1'b1;
      stall_i = 1'b0;
      expCnt = 0;
      applyStimulus(RT9, 5'd5, 5'd6, 5'd7, 32'hE1, 32'hE2, 32'hE3);
      sbq.push_back(mkSnap(RT8, 32'hE1, 32'hE2, 32'hE3, 5'd5, 5'd6, 5'd7, 1'b1, expCnt));
      advance();
      total++; expSnap = sbq.pop_front();
      if (obs !== expSnap) begin bad++; $display("FAIL post_reset_capture: got=%h want=%h", obs, expSnap); end
   endtask

   initial begin
      test_reset();
      test_capture();
      test_load_use();
      test_no_false_hazard();
      test_flush_hazard();
      test_stall();
      test_back_to_back();
      test_async_reset();
      total++;
      if (sbq.size() != 0) begin bad++; $display("FAIL scoreboard_drain: got=%0d want=0", sbq.size()); end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got=timeout want=finish");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline stage of the five-stage MIPS core: the register between decode and execute, plus load-use hazard detection and bubble insertion. It captures decoded control, operand data and register indices (rs, rt, rd) each cycle. It supplies the ID/EX rs/rt fields that the EX-stage forwarding logic compares against EX/MEM and MEM/WB destinations. It tells the PC and IF/ID register to hold when a load-use hazard requires a one-cycle stall.

## Interface
Parameters:
- DATA_W, 32, operand/immediate width
- REG_W, 5, register index width

Ports:
- clk_i  in  1  core clock; all state updates on rising edge
- rst_i  in  1  reset, asynchronous, active-low; clears all state immediately
- stall_i  in  1  global freeze (memory stall); holds every register, including the counter
- flush_i  in  1  branch/jump taken; the instruction entering ID/EX is squashed
- ctrl_i  in  9  decoded control {RegWrite, MemtoReg, MemRead, MemWrite, ALUSrc, ALUOp[1:0], RegDst, UsesRt}
- rs_data_i, rt_data_i, imm_i  in  DATA_W  register-file reads, sign-extended immediate
- rs_i, rt_i, rd_i  in  REG_W  IF/ID instruction fields
- ctrl_o  out  8  registered control, without UsesRt
- rs_data_o, rt_data_o, imm_o  out  DATA_W  registered data
- rs_o, rt_o, rd_o  out  REG_W  registered indices (ID/EX.Rs/Rt/Rd)
- valid_o  out  1  ID/EX holds a real instruction, not a bubble
- pc_write_o, ifid_write_o  out  1  low = hold PC / IF/ID this cycle
- bubble_cnt_o  out  32  count of load-use bubbles inserted since reset

## Operation
- Load-use hazard, combinational: hazard = ctrl_o.MemRead & valid_o & (rt_o != 0) & ((rt_o == rs_i) | (ctrl_i.UsesRt & rt_o == rt_i)).
- pc_write_o = ifid_write_o = ~hazard & ~stall_i.
- Per-cycle update, in priority order:
  1. stall_i = 1: hold all registers.
  2. flush_i = 1: load a bubble.
  3. hazard = 1: load a bubble and increment bubble_cnt_o.
  4. Otherwise: capture all inputs and set valid_o = 1.
- Bubble contents: ctrl_o = 0, valid_o = 0, rs_o/rt_o/rd_o = 0, data fields don't-care but driven 0. Zero indices guarantee the forwarding logic never matches a bubble.
- Flush together with hazard: one bubble, no counter increment; the squashed instruction was the dependent one.
- bubble_cnt_o wraps from 0xFFFF_FFFF to 0.

## Timing
- Latency: 1 cycle, inputs to outputs.
- Load-use costs exactly one bubble. The cycle after the bubble, the hazard clears because ID/EX now holds a bubble with MemRead = 0, and the held instruction proceeds.
- Reset values: all registered outputs 0; valid_o = 0; bubble_cnt_o = 0. pc_write_o and ifid_write_o read 1 while reset is asserted, provided stall_i = 0.
- Reset asserted mid-stall: state clears immediately. The first rising edge after rst_i releases captures normally.
- stall_i gates the hazard outputs combinationally in the same cycle. Hazard evaluation resumes on the held state once stall_i drops.

## Structure
- Shared package pipe_pkg holds:
  - CTRL_W and the bit positions of each control field
  - ALUOp encodings
  - the BUBBLE_CTRL constant
  The EX/MEM and MEM/WB stages reuse these.
- One combinational sub-module, hazard_detect, computes hazard from rt_o, ctrl_o.MemRead, valid_o, rs_i, rt_i and UsesRt. Everything else is flops in id_ex_stage.

## Test plan
- Plain capture: rs_i = 3, rt_i = 4, rd_i = 5, RegWrite = 1, rs_data_i = 0x11 → next cycle rs_o = 3, rt_o = 4, rd_o = 5, rs_data_o = 0x11, valid_o = 1; pc_write_o stays 1.
- Load-use: ID/EX holds lw with rt_o = 8; IF/ID rs_i = 8 → pc_write_o = ifid_write_o = 0 for one cycle; next cycle ctrl_o = 0, valid_o = 0, bubble_cnt_o = 1; the following cycle captures rs_i = 8 normally.
- No false hazard:
  - lw with rt_o = 0 and rs_i = 0 → no stall.
  - lw rt_o = 9, rt_i = 9, UsesRt = 0 → no stall.
- Flush plus hazard in the same cycle → one bubble, bubble_cnt_o unchanged, valid_o = 0.
- stall_i held 3 cycles during a hazard → all outputs frozen and bubble_cnt_o frozen; the bubble is inserted on the first edge after stall_i falls.
- rst_i pulsed low asynchronously between edges with valid_o = 1 and bubble_cnt_o = 7 → outputs 0 immediately, before the next clk_i edge.
